gbuff_c_reader: RTL and testbench
=================================

# gbuff_c_reader

Drain engine for the output-matrix (C) global buffer of the TPU. On a start command it issues sequential reads to the C buffer's read port (`index_out`/`out`) and captures the returned 128-bit words into a small credit-limited FIFO. It then serializes each word into narrow beats on a valid/ready stream toward the CFU response path. It is the reader counterpart of the systolic array, which fills the buffer.

## Interface
- `ADDR_BITS`, 16: C buffer index width.
- `DATA_BITS`, 128: C buffer word width.
- `OUT_BITS`, 32: stream beat width; `DATA_BITS % OUT_BITS == 0`, `RATIO = DATA_BITS/OUT_BITS`.
- `DEPTH`, 16384: C buffer depth in words; the address wrap point.
- `FIFO_DEPTH`, 4: capture FIFO entries (words), power of two.

Ports:
- `clk` in 1: single clock, posedge logic.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle command pulse, sampled only in IDLE.
- `base_addr` in ADDR_BITS: first word index, sampled with `start`.
- `len` in ADDR_BITS+1: word count, sampled with `start`.
- `abort` in 1: synchronous cancel.
- `rd_en` out 1: drives the buffer's `out` input.
- `rd_index` out ADDR_BITS: drives the buffer's `index_out` input.
- `rd_data` in DATA_BITS: the buffer's `data_out`.
- `m_valid` out 1: stream beat valid.
- `m_ready` in 1: stream beat accept.
- `m_data` out OUT_BITS: stream beat data.
- `m_last` out 1: final beat of the command.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on `start` with `len != 0`. The block latches `addr = base_addr`, `remaining = len`, `pending_beats = len*RATIO`.
- `start` with `len == 0`: `done` pulses the next cycle, no reads are issued, and the block stays IDLE.
- RUN: a read is issued (`rd_en=1`, `rd_index=addr`) in a cycle when `fifo_count + inflight - pop < FIFO_DEPTH`.
  - `inflight` = 1 if a read was issued in the previous cycle.
  - `pop` = 1 if a FIFO word's last beat is accepted this cycle.
- After each issue: `addr` increments and wraps from `DEPTH-1` to 0; `remaining` decrements. The last issue moves the block to DRAIN.
- Capture: the buffer registers `rd_data` on the negedge following a posedge where `rd_en=1`. The reader pushes `rd_data` into the FIFO at the next posedge iff `inflight`. `rd_data` is never sampled otherwise, because it holds a stale value when `rd_en=0`.
- Serializer: the FIFO head is emitted as RATIO beats, lane 0 (bits `OUT_BITS-1:0`) first. A beat advances only on `m_valid && m_ready`. The head pops on acceptance of lane RATIO-1.
- `m_last` is high with the final lane of the final word only.
- DRAIN → IDLE when the final beat is accepted; `done` pulses in that same cycle.
- `abort` (any state): the block returns to IDLE next cycle and flushes the FIFO, serializer lane and inflight flag. `m_valid` and `rd_en` drop. No `done` is pulsed.
- `start` while busy is ignored. When `abort` and `start` coincide in IDLE, `abort` wins.
- An in-flight read returning after `abort` is discarded.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, lane 0.
- An asynchronous `rst` mid-command drops everything immediately.
- The first `rd_en` is asserted the cycle after `start`.
- Start-to-first-`m_valid` = 3 cycles: issue at T+1, capture at T+2, `m_valid` registered at T+3.
- `m_valid` and `m_data` are stable until accepted. Once `m_valid` is high it is never retracted except by `abort` or `rst`.
- Steady state with `m_ready` held at 1:
  - `RATIO = 1`: one word per cycle.
  - `RATIO = 4`: one read every 4 cycles, and the FIFO never overflows.
- FIFO full and a pop in the same cycle: a new issue is allowed.

## Structure
- Shared package `tpu_pkg` holds the state encoding (`RD_IDLE`, `RD_RUN`, `RD_DRAIN`) and the `DATA_BITS`, `ADDR_BITS` and `DEPTH` defaults used by all global buffers.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count) is instantiated for capture storage.
- FSM, credit logic and serializer live in `gbuff_c_reader`.

## Test plan
- Reset: hold `rst`, then release → all outputs 0. `start` with `base_addr=0x10`, `len=2`, `m_ready=1` → `rd_index` 0x10 then 0x11. Eight beats emerge in lane order; `m_last` is on beat 8 and `done` is in the same cycle.
- Backpressure: `len=8`, `m_ready` toggling 1-0-0-1 → at most FIFO_DEPTH words are outstanding, no beat is lost or duplicated, and `m_data` is held while `m_ready=0`.
- Wrap: `base_addr=16383`, `len=3` → `rd_index` sequence 16383, 0, 1.
- Zero length: `start` with `len=0` → `done` pulses at T+1, `rd_en` never rises, `busy` stays 0.
- Abort: `abort` at the cycle of the 3rd beat of `len=4` → IDLE next cycle, `m_valid=0`, no `done`. A following `start` with `len=1` streams exactly 4 correct beats.
- Async reset mid-RUN: assert `rst` between clock edges → outputs clear immediately; a subsequent command behaves as from cold reset.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: definitions shared by the TPU global-buffer blocks.
//   - rd_state_e : reader FSM encoding (RD_IDLE, RD_RUN, RD_DRAIN)
//   - TPU_*      : default buffer geometry (index width, word width, depth)
//   - wrap_inc   : buffer index increment with wrap at the buffer depth
package tpu_pkg;

    localparam int TPU_ADDR_BITS = 16;
    localparam int TPU_DATA_BITS = 128;
    localparam int TPU_DEPTH     = 16384;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

    // Next buffer index; indices run 0..DEPTH-1 and wrap back to 0.
    function automatic logic [TPU_ADDR_BITS-1:0] wrap_inc(
        input logic [TPU_ADDR_BITS-1:0] idx,
        input int                       depth
    );
        if (int'(idx) == depth - 1)
            return '0;
        return idx + TPU_ADDR_BITS'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH a power of two.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous flush (wins over push/pop)
//   push, din  : write request and data (caller must not push when full)
//   pop        : read request (caller must not pop when empty)
//   dout       : head entry, valid while !empty
//   full/empty : status, count : entries held (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only observed once written.
    always_ff @(posedge clk) begin
        if (push && !clr)
            mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/gbuff_c_reader.sv
// gbuff_c_reader: drains the C global buffer onto a narrow valid/ready stream.
// A start command issues sequential buffer reads (credit limited by the
// capture FIFO), captures each returned word, and emits it as RATIO beats,
// lane 0 first.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, base_addr, len    : command (sampled in IDLE only)
//   abort                    : synchronous cancel, back to IDLE, no done
//   rd_en, rd_index, rd_data : C buffer read port (data returns next cycle)
//   m_valid/m_ready/m_data   : output beat stream, m_last on final beat
//   busy                     : not IDLE
//   done                     : one-cycle completion pulse
module gbuff_c_reader
    import tpu_pkg::*;
#(
    parameter int ADDR_BITS  = TPU_ADDR_BITS,
    parameter int DATA_BITS  = TPU_DATA_BITS,
    parameter int OUT_BITS   = 32,
    parameter int DEPTH      = TPU_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   len,
    input  logic                 abort,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_index,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_BITS-1:0]  m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

    localparam int RATIO  = DATA_BITS / OUT_BITS;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PB_W   = ADDR_BITS + 1 + LANE_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    rd_state_e            state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS:0]   remaining_q, remaining_d;
    logic [PB_W-1:0]      pending_q, pending_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic                 inflight_q, inflight_d;
    logic                 zdone_q, zdone_d;

    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [RATIO-1:0][OUT_BITS-1:0] head_lanes;
    logic                 unused_fifo_full;

    logic issue, beat_acc, lane_last, pop, push, credit_ok, final_acc;

    assign head_lanes       = fifo_dout;
    assign unused_fifo_full = fifo_full;

    assign lane_last = (int'(lane_q) == RATIO - 1);
    assign beat_acc  = !fifo_empty && m_ready;
    assign pop       = beat_acc && lane_last;
    assign final_acc = beat_acc && (pending_q == PB_W'(1));

    // rd_data is only meaningful the cycle after an issue; abort drops it.
    assign push = inflight_q && !abort;

    // A new read needs a slot counting the word still returning from the
    // buffer; a slot freed by this cycle's pop is usable immediately.
    assign credit_ok = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q))
                     < ((CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop));

    assign issue = (state_q == RD_RUN) && credit_ok && !abort;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        pending_d   = pending_q;
        lane_d      = lane_q;
        inflight_d  = issue;
        zdone_d     = 1'b0;

        if (abort) begin
            state_d     = RD_IDLE;
            remaining_d = '0;
            pending_d   = '0;
            lane_d      = '0;
            inflight_d  = 1'b0;
        end else begin
            if (beat_acc) begin
                lane_d    = lane_last ? '0 : lane_q + LANE_W'(1);
                pending_d = pending_q - PB_W'(1);
            end
            case (state_q)
                RD_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            zdone_d = 1'b1;
                        end else begin
                            state_d     = RD_RUN;
                            addr_d      = base_addr;
                            remaining_d = len;
                            pending_d   = PB_W'(len) * PB_W'(RATIO);
                        end
                    end
                end
                RD_RUN: begin
                    if (issue) begin
                        addr_d      = wrap_inc(addr_q, DEPTH);
                        remaining_d = remaining_q - (ADDR_BITS+1)'(1);
                        if (remaining_q == (ADDR_BITS+1)'(1))
                            state_d = RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (final_acc)
                        state_d = RD_IDLE;
                end
                default: state_d = RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            pending_q   <= '0;
            lane_q      <= '0;
            inflight_q  <= 1'b0;
            zdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            lane_q      <= lane_d;
            inflight_q  <= inflight_d;
            zdone_q     <= zdone_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_cap_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (abort),
        .push  (push),
        .din   (rd_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rd_en    = issue;
    assign rd_index = addr_q;
    assign m_valid  = !fifo_empty;
    // Gated so the unreset FIFO storage never shows on the port.
    assign m_data   = m_valid ? head_lanes[lane_q] : '0;
    assign m_last   = m_valid && (pending_q == PB_W'(1));
    assign busy     = (state_q != RD_IDLE);
    assign done     = zdone_q || ((state_q == RD_DRAIN) && final_acc && !abort);

endmodule

// File: tb/tb_gbuff_c_reader.sv
module tb_gbuff_c_reader;

    localparam int AB    = 16;
    localparam int DB    = 128;
    localparam int OB    = 32;
    localparam int DEP   = 16384;
    localparam int FD    = 4;
    localparam int RATIO = DB / OB;

    logic          clk, rst, start, abort, m_ready;
    logic [AB-1:0] base_addr;
    logic [AB:0]   len;
    logic          rd_en, m_valid, m_last, busy, done;
    logic [AB-1:0] rd_index;
    logic [DB-1:0] rd_data;
    logic [OB-1:0] m_data;

    gbuff_c_reader #(
        .ADDR_BITS (AB), .DATA_BITS (DB), .OUT_BITS (OB),
        .DEPTH (DEP), .FIFO_DEPTH (FD)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .base_addr (base_addr),
        .len (len), .abort (abort), .rd_en (rd_en), .rd_index (rd_index),
        .rd_data (rd_data), .m_valid (m_valid), .m_ready (m_ready),
        .m_data (m_data), .m_last (m_last), .busy (busy), .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // C buffer model: read sampled at posedge, data appears at the negedge.
    // Outside a read return the port shows junk.
    logic [DB-1:0] mem [0:DEP-1];
    logic          rd_pend;
    logic [AB-1:0] idx_l;

    always @(posedge clk) begin
        rd_pend <= rd_en;
        idx_l   <= rd_index;
    end

    always @(negedge clk) begin
        if (rd_pend) rd_data <= mem[idx_l];
        else         rd_data <= {$urandom, $urandom, $urandom, $urandom};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference expectations: read index order and beat stream per command.
    int            exp_idx [$];
    logic [OB-1:0] exp_beat [$];
    logic          exp_last [$];
    int            issued, wpop, acc_beats;
    logic          zdone_exp, done_seen, hold_pend;
    logic [OB-1:0] hold_data;

    task automatic mon();
        logic pop_now, exp_done, el;
        logic [OB-1:0] eb;
        if (rst) begin
            hold_pend = 1'b0;
            return;
        end
        pop_now  = m_valid && m_ready && (acc_beats % RATIO == RATIO - 1);
        exp_done = zdone_exp;
        if (rd_en) begin
            if (exp_idx.size() == 0) chk("rd_extra", 1, 0);
            else chk("rd_index", rd_index, exp_idx.pop_front());
            chk("credit", (issued - wpop - int'(pop_now)) < FD, 1);
            issued++;
        end
        if (hold_pend) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, hold_data);
        end
        if (m_valid && m_ready) begin
            if (exp_beat.size() == 0) chk("beat_extra", 1, 0);
            else begin
                eb = exp_beat.pop_front();
                el = exp_last.pop_front();
                chk("m_data", m_data, eb);
                chk("m_last", m_last, el);
                exp_done = exp_done || el;
            end
            acc_beats++;
            if (pop_now) wpop++;
        end
        if (done || exp_done) chk("done", done, exp_done);
        if (done) done_seen = 1'b1;
        hold_pend = m_valid && !m_ready && !abort;
        hold_data = m_data;
    endtask

    always @(negedge clk) mon();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic clear_exp();
        exp_idx.delete();
        exp_beat.delete();
        exp_last.delete();
        issued = 0; wpop = 0; acc_beats = 0;
        done_seen = 1'b0;
    endtask

    // Build the expected stream and pulse start; returns at posedge+1 of T+1.
    task automatic start_cmd(input int base, input int n);
        logic [DB-1:0] w;
        int a;
        clear_exp();
        for (int i = 0; i < n; i++) begin
            a = (base + i) % DEP;
            exp_idx.push_back(a);
            w = mem[a];
            for (int l = 0; l < RATIO; l++) begin
                exp_beat.push_back(w[l*OB +: OB]);
                exp_last.push_back((i == n - 1) && (l == RATIO - 1));
            end
        end
        base_addr = AB'(base);
        len       = (AB+1)'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_cmd(input int base, input int n, input int mode);
        int  cyc;
        logic seen_rd, seen_v;
        seen_rd = 0; seen_v = 0;
        m_ready = 1'b0;
        start_cmd(base, n);
        cyc = 1;
        while (!done_seen && cyc < 600) begin
            if (!seen_rd && rd_en)   begin seen_rd = 1; chk("first_rd_cycle", cyc, 1); end
            if (!seen_v  && m_valid) begin seen_v  = 1; chk("first_valid_cycle", cyc, 3); end
            m_ready = rdy(mode, cyc);
            tick();
            cyc++;
        end
        chk("cmd_done_seen", done_seen, 1);
        if (mode == 0) chk("done_cycle", cyc - 1, 2 + n * RATIO);
        chk("beats_left", exp_beat.size(), 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", m_valid, 0);
        m_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEP; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        rst = 1'b1; start = 0; abort = 0; m_ready = 0;
        base_addr = '0; len = '0; zdone_exp = 0; hold_pend = 0;
        clear_exp();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {rd_en, rd_index, m_valid, m_data, m_last, busy, done}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        chk("post_rst_outputs", {rd_en, rd_index, m_valid, m_data, m_last, busy, done}, '0);

        // Directed first command, then backpressure and wrap
        run_cmd(16'h10, 2, 0);
        run_cmd(100, 8, 1);
        run_cmd(16383, 3, 0);
        run_cmd(500, 8, 0);

        // Zero length
        len = '0; base_addr = 16'h20; start = 1'b1;
        tick();
        start = 1'b0; zdone_exp = 1'b1;
        chk("zero_busy", busy, 0);
        chk("zero_rd_en", rd_en, 0);
        tick();
        zdone_exp = 1'b0;
        chk("zero_done_once", done, 0);
        chk("zero_busy2", busy, 0);

        // Abort and start together in IDLE: abort wins
        abort = 1'b1; start = 1'b1; len = 17'd2; base_addr = 16'h30;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", busy, 0);
        repeat (3) tick();

        // Abort in the cycle of the third beat
        m_ready = 1'b1;
        start_cmd(200, 4);
        for (int c = 0; c < 50 && acc_beats < 2; c++) tick();
        chk("abort_reach_beat3", acc_beats, 2);
        abort = 1'b1; m_ready = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd_en", rd_en, 0);
        clear_exp();
        m_ready = 1'b1;
        repeat (4) tick();
        run_cmd(300, 1, 0);

        // Random commands, biased toward the wrap point
        for (int k = 0; k < 6; k++) begin
            int b, n;
            b = (k % 2) ? DEP - 1 - $urandom_range(0, 3) : $urandom_range(0, DEP - 1);
            n = $urandom_range(1, 8);
            run_cmd(b, n, $urandom_range(0, 2));
        end

        // Asynchronous reset mid-run
        m_ready = 1'b1;
        start_cmd(1000, 6);
        repeat (4) tick();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {rd_en, rd_index, m_valid, m_data, m_last, busy, done}, '0);
        clear_exp();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        run_cmd(16382, 2, 0);
        run_cmd(7, 5, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
